// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and index sizing.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index WIDTH operand bits, never less than one.
    function automatic int idx_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_fa_bit.sv
// One-bit full adder cell used as the serial datapath; purely combinational.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one operand bit per RUN cycle, done pulses WIDTH+1 cycles after start.
// Optional signed-overflow output is enabled with macro SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IW = idx_bits(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             fa_s, fa_co;

    fa_bit u_fa (
        .x  (a_q[idx_q]),
        .y  (b_q[idx_q]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = fa_s;
                carry_d      = fa_co;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is the running carry on the last RUN cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_d = carry_q ^ fa_co;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q == RUN) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         c;
    logic         busy, done, carry;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic sum, carry and signed overflow.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    task automatic scramble();
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tc);
        logic [W:0] r;
        r = ref_add(ta, tb_, tc);
        check({tag, "_sum"}, 64'(sum), 64'(r[W-1:0]));
        check({tag, "_carry"}, 64'(carry), 64'(r[W]));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb_, r[W-1:0])));
`endif
    endtask

    // One operation; j counts negedges after the accepting edge (j=0 is first RUN cycle).
    // disturb pulses start with new operands mid-RUN, which must be ignored.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input bit disturb);
        int first_done;
        int n_done;
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1;
        for (int j = 0; j <= W + 3; j++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = j;
            end
            if (j == 0) begin
                start = 1'b0;
                scramble();
            end
            if (disturb && j == 2) begin
                a = 8'h55; start = 1'b1;
            end
            if (disturb && j == 3) start = 1'b0;
            if (j == W) check_result(tag, ta, tb_, tc);
            if (j == 0 || j == W - 1) check({tag, "_busy_run"}, 64'(busy), 64'd1);
            if (j == W + 2) begin
                check({tag, "_idle_busy"}, 64'(busy), 64'd0);
                check_result({tag, "_hold"}, ta, tb_, tc);
            end
        end
        check({tag, "_latency"}, 64'(first_done), 64'(W));
        check({tag, "_ndone"}, 64'(n_done), 64'd1);
    endtask

    logic [W-1:0] qa[4], qb[4];
    logic         qc[4];
    int           nd, fd;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("d0f01", 8'h0F, 8'h01, 1'b0, 1'b0);
        run_op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("d7f00c", 8'h7F, 8'h00, 1'b1, 1'b0);
        run_op("dmid", 8'h3C, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Reset during the fourth RUN cycle abandons the operation.
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; c = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_sum", 64'(sum), 64'd0);
        check("mrst_carry", 64'(carry), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int j = 0; j < W + 3; j++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("mrst_nodone", 64'(nd), 64'd0);
        run_op("after_rst", 8'h01, 8'h02, 1'b0, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles.
        for (int n = 0; n < 4; n++) begin
            qa[n] = W'($urandom); qb[n] = W'($urandom); qc[n] = 1'($urandom);
        end
        @(negedge clk);
        a = qa[0]; b = qb[0]; c = qc[0]; start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            nd = 0; fd = -1;
            for (int j = 0; j <= W + 1; j++) begin
                @(negedge clk);
                if (done) begin
                    nd++;
                    if (fd < 0) fd = j;
                end
                if (j == W) check_result($sformatf("held%0d", n), qa[n], qb[n], qc[n]);
                if (j == W + 1 && n < 3) begin
                    a = qa[n+1]; b = qb[n+1]; c = qc[n+1];
                end else begin
                    scramble();
                end
            end
            check($sformatf("held%0d_latency", n), 64'(fd), 64'(W));
            check($sformatf("held%0d_ndone", n), 64'(nd), 64'd1);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A; captured on an accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: operand B; captured on an accepted start.
REQ-007 SHALL have port c, input, 1 bit: carry-in; captured on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking sum and carry valid.
REQ-010 SHALL have port sum, output, WIDTH bits: result, A+B+c modulo 2^WIDTH.
REQ-011 SHALL have port carry, output, 1 bit: carry-out of bit WIDTH-1.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at a rising edge, capture a, b and c, clear the bit index, and enter RUN.
REQ-014 SHALL, in each RUN cycle, add operand bit [idx] of A and B with the running carry through one full-adder bit cell, store the sum bit into result bit [idx], update the running carry, and increment idx.
REQ-015 SHALL leave RUN for DONE after the cycle that processes idx=WIDTH-1, so RUN lasts exactly WIDTH cycles.
REQ-016 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-017 SHALL give a fixed latency: an accepted start at edge E0 makes done high in the cycle after edge E0+WIDTH, with no dependence on operand values.
REQ-018 SHALL hold sum and carry stable from DONE until the next accepted start, including while idle.
REQ-019 SHALL ignore start in RUN and DONE; changes on a, b and c after capture SHALL NOT affect the result.
REQ-020 SHALL accept a start held high in the IDLE cycle that follows DONE, allowing back-to-back operations one IDLE cycle apart.
REQ-021 SHALL compute wrap-around modulo 2^WIDTH, with the overflow bit reported only on carry.

Reset
REQ-022 SHALL, on rst=1, immediately force state=IDLE, idx=0, busy=0, done=0, sum=0, carry=0, independent of clk.
REQ-023 SHALL, when reset occurs mid-RUN, abandon the operation and assert no done pulse for it.
REQ-024 SHALL sample start at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro SERIAL_ADD_OVF_EN defined, add output ovf (1 bit), equal to the signed two's-complement overflow (carry into MSB XOR carry out of MSB), registered with sum, valid on done, and reset to 0.
REQ-026 SHALL, without SERIAL_ADD_OVF_EN, have no ovf port and no related logic; all other behaviour SHALL be identical in both builds.

Structure
REQ-027 SHALL take the state enumeration (IDLE, RUN, DONE) and the index-width function/constant from shared package serial_add_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module fa_bit (inputs x, y, ci; outputs s, co) as the per-bit datapath cell.

Verification
REQ-029 SHALL cover: WIDTH=8, a=0x0F, b=0x01, c=0 -> sum=0x10, carry=0, done exactly 9 cycles after start edge.
REQ-030 SHALL cover: a=0xFF, b=0x01, c=0 -> sum=0x00, carry=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-031 SHALL cover: a=0x7F, b=0x00, c=1 -> sum=0x80, carry=0; with SERIAL_ADD_OVF_EN, ovf=1.
REQ-032 SHALL cover: start pulsed with a=0x55 at cycle 3 of RUN and operands changed mid-RUN -> first result unchanged, no second operation started.
REQ-033 SHALL cover: rst asserted at RUN cycle 4 -> outputs 0 immediately, no done pulse; next start a=0x01, b=0x02 -> sum=0x03.
REQ-034 SHALL cover: start held high continuously -> done pulses every WIDTH+2 cycles, with each result matching its captured operands.
